// File: rtl/z88_sram_bridge.sv
// Byte-wide core RAM port to asynchronous SRAM bridge.
// Registered strobes with programmable read-wait and write setup/pulse/hold.
module z88_sram_bridge #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16,
    parameter int RD_WAIT  = 1,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1,
    localparam int LANES   = DATA_W / 8,
    localparam int LB      = $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata,
    output logic                 ack,
    output logic                 busy,
    output logic [ADDR_W-LB-1:0] sram_addr,
    output logic [LANES-1:0]     sram_be_n,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [DATA_W-1:0]    sram_dq_o,
    output logic                 sram_dq_oe,
    input  logic [DATA_W-1:0]    sram_dq_i
);

    localparam int LBW = (LB > 0) ? LB : 1;

    localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
    localparam logic [3:0] WS_CNT = 4'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
    localparam logic [3:0] WP_CNT = 4'(WR_PULSE - 1);
    localparam logic [3:0] WH_CNT = 4'((WR_HOLD > 0) ? WR_HOLD - 1 : 0);

    typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, ACK} state_t;

    state_t                state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic [LBW-1:0]        lane, lane_d, lane_in;
    logic [7:0]            rdata_d;
    logic                  ack_d;
    logic [ADDR_W-LB-1:0]  sram_addr_d;
    logic [LANES-1:0]      be_n_d;
    logic                  ce_n_d, oe_n_d, we_n_d, dq_oe_d;
    logic [DATA_W-1:0]     dq_o_d, lane_shift;

    generate
        if (LB == 0) begin : g_one_lane
            assign lane_in = '0;
        end else begin : g_multi_lane
            assign lane_in = addr[LB-1:0];
        end
    endgenerate

    assign lane_shift = sram_dq_i >> {lane, 3'b000};
    assign busy = (state != IDLE);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lane_d      = lane;
        rdata_d     = rdata;
        ack_d       = 1'b0;
        sram_addr_d = sram_addr;
        be_n_d      = sram_be_n;
        ce_n_d      = sram_ce_n;
        oe_n_d      = sram_oe_n;
        we_n_d      = sram_we_n;
        dq_oe_d     = sram_dq_oe;
        dq_o_d      = sram_dq_o;
        unique case (state)
            IDLE: begin
                if (req) begin
                    sram_addr_d = addr[ADDR_W-1:LB];
                    lane_d      = lane_in;
                    ce_n_d      = 1'b0;
                    be_n_d      = ~(LANES'(1) << lane_in);
                    if (we) begin
                        dq_oe_d = 1'b1;
                        dq_o_d  = {LANES{wdata}};
                        if (WR_SETUP == 0) begin
                            state_d = WP;
                            cnt_d   = WP_CNT;
                            we_n_d  = 1'b0;
                        end else begin
                            state_d = WS;
                            cnt_d   = WS_CNT;
                        end
                    end else begin
                        oe_n_d  = 1'b0;
                        state_d = RD;
                        cnt_d   = RD_CNT;
                    end
                end
            end
            RD: begin
                if (cnt == 4'd0) begin
                    rdata_d = lane_shift[7:0];
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = '1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WS: begin
                if (cnt == 4'd0) begin
                    state_d = WP;
                    cnt_d   = WP_CNT;
                    we_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WP: begin
                if (cnt == 4'd0) begin
                    we_n_d = 1'b1;
                    if (WR_HOLD == 0) begin
                        ce_n_d  = 1'b1;
                        be_n_d  = '1;
                        dq_oe_d = 1'b0;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = WH;
                        cnt_d   = WH_CNT;
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WH: begin
                if (cnt == 4'd0) begin
                    ce_n_d  = 1'b1;
                    be_n_d  = '1;
                    dq_oe_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ACK: begin
                // req is deliberately ignored here to force an idle gap
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lane       <= '0;
            rdata      <= 8'd0;
            ack        <= 1'b0;
            sram_addr  <= '0;
            sram_be_n  <= '1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_dq_o  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            lane       <= lane_d;
            rdata      <= rdata_d;
            ack        <= ack_d;
            sram_addr  <= sram_addr_d;
            sram_be_n  <= be_n_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_dq_oe <= dq_oe_d;
            sram_dq_o  <= dq_o_d;
        end
    end

endmodule

// File: tb/tb_z88_sram_bridge.sv
// Directed bench for z88_sram_bridge: 16-, 32- and 8-bit SRAM configurations.
module tb_z88_sram_bridge;

    logic        clk, reset_n;
    logic [18:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          n_cmp, n_bad;

    logic        req16, ack16, busy16, ce16, oe16, we16, dqoe16;
    logic [7:0]  rdata16;
    logic [17:0] sa16;
    logic [1:0]  be16;
    logic [15:0] dqo16, dqi16;

    logic        req32, ack32, busy32, ce32, oe32, we32, dqoe32;
    logic [7:0]  rdata32;
    logic [16:0] sa32;
    logic [3:0]  be32;
    logic [31:0] dqo32, dqi32;

    logic        req8, ack8, busy8, ce8, oe8, we8, dqoe8;
    logic [7:0]  rdata8;
    logic [18:0] sa8;
    logic [0:0]  be8;
    logic [7:0]  dqo8, dqi8;

    z88_sram_bridge #(.DATA_W(16)) u16 (
        .clk(clk), .reset_n(reset_n), .req(req16), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata16), .ack(ack16), .busy(busy16),
        .sram_addr(sa16), .sram_be_n(be16), .sram_ce_n(ce16),
        .sram_oe_n(oe16), .sram_we_n(we16), .sram_dq_o(dqo16),
        .sram_dq_oe(dqoe16), .sram_dq_i(dqi16));

    z88_sram_bridge #(.DATA_W(32)) u32 (
        .clk(clk), .reset_n(reset_n), .req(req32), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata32), .ack(ack32), .busy(busy32),
        .sram_addr(sa32), .sram_be_n(be32), .sram_ce_n(ce32),
        .sram_oe_n(oe32), .sram_we_n(we32), .sram_dq_o(dqo32),
        .sram_dq_oe(dqoe32), .sram_dq_i(dqi32));

    z88_sram_bridge #(.DATA_W(8), .WR_SETUP(0), .WR_PULSE(1), .WR_HOLD(0)) u8 (
        .clk(clk), .reset_n(reset_n), .req(req8), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata8), .ack(ack8), .busy(busy8),
        .sram_addr(sa8), .sram_be_n(be8), .sram_ce_n(ce8),
        .sram_oe_n(oe8), .sram_we_n(we8), .sram_dq_o(dqo8),
        .sram_dq_oe(dqoe8), .sram_dq_i(dqi8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe safety across every configuration
    always @(negedge clk) begin
        if (reset_n) begin
            n_cmp = n_cmp + 1;
            if (!oe16 && (!we16 || dqoe16) || !oe32 && (!we32 || dqoe32)
                || !oe8 && (!we8 || dqoe8)) begin
                n_bad = n_bad + 1;
                $display("FAIL strobe_overlap got oe=%b%b%b we=%b%b%b dqoe=%b%b%b want no overlap",
                         oe16, oe32, oe8, we16, we32, we8, dqoe16, dqoe32, dqoe8);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        n_cmp = n_cmp + 4;
        if ({ce16, oe16, we16, be16, dqoe16, ack16, busy16} !== 8'b1111_1000) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_strobes16 got %b want 11111000",
                     {ce16, oe16, we16, be16, dqoe16, ack16, busy16});
        end
        if ({rdata16, sa16, dqo16} !== 42'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_data16 got %h/%h/%h want 0", rdata16, sa16, dqo16);
        end
        if ({be32, ce32, oe32, we32, dqoe32} !== 8'b1111_1110) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_strobes32 got %b want 11111110",
                     {be32, ce32, oe32, we32, dqoe32});
        end
        if ({be8, ce8, oe8, we8, dqoe8, busy8} !== 6'b111100) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_strobes8 got %b want 111100",
                     {be8, ce8, oe8, we8, dqoe8, busy8});
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_read16;
        addr = 19'h00003; we = 1'b0; dqi16 = 16'hA55A; req16 = 1'b1;
        tick;
        req16 = 1'b0;
        n_cmp = n_cmp + 3;
        if (sa16 !== 18'h00001 || be16 !== 2'b01) begin
            n_bad = n_bad + 1;
            $display("FAIL rd16_addr got %h/%b want 00001/01", sa16, be16);
        end
        if ({ce16, oe16, we16, dqoe16, ack16, busy16} !== 6'b001001) begin
            n_bad = n_bad + 1;
            $display("FAIL rd16_c1 got %b want 001001",
                     {ce16, oe16, we16, dqoe16, ack16, busy16});
        end
        tick;
        if ({ack16, oe16, ce16, be16} !== 5'b11111 || rdata16 !== 8'hA5) begin
            n_bad = n_bad + 1;
            $display("FAIL rd16_ack got %b rdata=%h want 11111 rdata=a5",
                     {ack16, oe16, ce16, be16}, rdata16);
        end
        tick;
        n_cmp = n_cmp + 1;
        if (ack16 !== 1'b0 || busy16 !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL rd16_done got ack=%b busy=%b want 0 0", ack16, busy16);
        end
    endtask

    task automatic test_write16;
        logic [5:0] wlow, oeh, ackv;
        addr = 19'h00010; we = 1'b1; wdata = 8'h3C; req16 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            wlow[i] = ~we16;
            oeh[i]  = dqoe16;
            ackv[i] = ack16;
            if (i == 0) begin
                wdata = 8'hFF;
                n_cmp = n_cmp + 1;
                if (sa16 !== 18'h00008 || be16 !== 2'b10 || dqo16 !== 16'h3C3C) begin
                    n_bad = n_bad + 1;
                    $display("FAIL wr16_setup got %h/%b/%h want 00008/10/3c3c",
                             sa16, be16, dqo16);
                end
            end
            if (ack16) req16 = 1'b0;
        end
        n_cmp = n_cmp + 3;
        if (wlow !== 6'b000110) begin
            n_bad = n_bad + 1;
            $display("FAIL wr16_we_n got %b want 000110", wlow);
        end
        if (oeh !== 6'b001111) begin
            n_bad = n_bad + 1;
            $display("FAIL wr16_dq_oe got %b want 001111", oeh);
        end
        if (ackv !== 6'b010000) begin
            n_bad = n_bad + 1;
            $display("FAIL wr16_ack got %b want 010000", ackv);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ackv, oel, bsy;
        addr = 19'h00002; we = 1'b0; dqi16 = 16'h1234; req16 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            ackv[i] = ack16;
            oel[i]  = ~oe16;
            bsy[i]  = busy16;
            if (i == 3) req16 = 1'b0;
        end
        n_cmp = n_cmp + 4;
        if (ackv !== 8'b0001_0010) begin
            n_bad = n_bad + 1;
            $display("FAIL b2b_ack got %b want 00010010", ackv);
        end
        if (oel !== 8'b0000_1001) begin
            n_bad = n_bad + 1;
            $display("FAIL b2b_oe got %b want 00001001", oel);
        end
        if (bsy !== 8'b0001_1011) begin
            n_bad = n_bad + 1;
            $display("FAIL b2b_busy got %b want 00011011", bsy);
        end
        if (rdata16 !== 8'h34 || sa16 !== 18'h00001) begin
            n_bad = n_bad + 1;
            $display("FAIL b2b_data got %h/%h want 34/00001", rdata16, sa16);
        end
    endtask

    task automatic test_wide32;
        addr = 19'h00007; we = 1'b0; dqi32 = 32'h11223344; req32 = 1'b1;
        tick;
        req32 = 1'b0;
        n_cmp = n_cmp + 4;
        if (be32 !== 4'b0111 || sa32 !== 17'h00001 || oe32 !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL rd32_c1 got %b/%h/%b want 0111/00001/0", be32, sa32, oe32);
        end
        tick;
        if (ack32 !== 1'b1 || rdata32 !== 8'h11) begin
            n_bad = n_bad + 1;
            $display("FAIL rd32_ack got ack=%b rdata=%h want 1 11", ack32, rdata32);
        end
        tick;
        we = 1'b1; wdata = 8'h5E; req32 = 1'b1;
        tick;
        req32 = 1'b0;
        if (dqo32 !== 32'h5E5E5E5E || dqoe32 !== 1'b1 || be32 !== 4'b0111) begin
            n_bad = n_bad + 1;
            $display("FAIL wr32_c1 got %h/%b/%b want 5e5e5e5e/1/0111", dqo32, dqoe32, be32);
        end
        repeat (4) tick;
        if (ack32 !== 1'b1 || dqoe32 !== 1'b0 || ce32 !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL wr32_ack got %b%b%b want 101", ack32, dqoe32, ce32);
        end
        tick;
    endtask

    task automatic test_narrow8;
        addr = 19'h01234; we = 1'b1; wdata = 8'h77; req8 = 1'b1;
        tick;
        req8 = 1'b0;
        n_cmp = n_cmp + 4;
        if ({we8, be8, dqoe8, ack8} !== 4'b0010 || sa8 !== 19'h01234 || dqo8 !== 8'h77) begin
            n_bad = n_bad + 1;
            $display("FAIL wr8_c1 got %b %h %h want 0010 01234 77",
                     {we8, be8, dqoe8, ack8}, sa8, dqo8);
        end
        tick;
        if ({ack8, we8, dqoe8, ce8} !== 4'b1101) begin
            n_bad = n_bad + 1;
            $display("FAIL wr8_ack got %b want 1101", {ack8, we8, dqoe8, ce8});
        end
        tick;
        addr = 19'h00042; we = 1'b0; dqi8 = 8'h9C; req8 = 1'b1;
        tick;
        req8 = 1'b0;
        if (oe8 !== 1'b0 || be8 !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL rd8_c1 got oe=%b be=%b want 0 0", oe8, be8);
        end
        tick;
        if (ack8 !== 1'b1 || rdata8 !== 8'h9C) begin
            n_bad = n_bad + 1;
            $display("FAIL rd8_ack got ack=%b rdata=%h want 1 9c", ack8, rdata8);
        end
        tick;
    endtask

    task automatic test_reset_mid_write;
        logic seen_ack;
        addr = 19'h00020; we = 1'b1; wdata = 8'hA1; req16 = 1'b1;
        tick;
        req16 = 1'b0;
        tick;
        n_cmp = n_cmp + 5;
        if (we16 !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_wp_entry got we_n=%b want 0", we16);
        end
        reset_n = 1'b0;
        #1;
        if ({we16, ce16, dqoe16, busy16, ack16} !== 5'b11000) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_async got %b want 11000", {we16, ce16, dqoe16, busy16, ack16});
        end
        if (rdata16 !== 8'h00 || dqo16 !== 16'h0000) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_data got %h/%h want 00/0000", rdata16, dqo16);
        end
        seen_ack = 1'b0;
        repeat (2) begin
            tick;
            seen_ack = seen_ack | ack16;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
            tick;
            seen_ack = seen_ack | ack16;
        end
        if (seen_ack !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_no_ack got %b want 0", seen_ack);
        end
        addr = 19'h00005; we = 1'b0; dqi16 = 16'hBEEF; req16 = 1'b1;
        tick;
        req16 = 1'b0;
        tick;
        if (ack16 !== 1'b1 || rdata16 !== 8'hBE || sa16 !== 18'h00002) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_reread got ack=%b rdata=%h addr=%h want 1 be 00002",
                     ack16, rdata16, sa16);
        end
        tick;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 1'b0;
        addr = '0; we = 1'b0; wdata = '0;
        req16 = 1'b0; req32 = 1'b0; req8 = 1'b0;
        dqi16 = '0; dqi32 = '0; dqi8 = '0;
        test_reset;
        test_read16;
        test_write16;
        test_back_to_back;
        test_wide32;
        test_narrow8;
        test_reset_mid_write;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
